// File: rtl/axis_data_mover_pkg.sv
// Shared types and width helpers for the AXI-stream sweep data mover.
package axis_data_mover_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_REQUEST, S_RESPONSE, S_EMIT, S_FINISH
  } state_e;

  localparam int MAX_CHANNELS = 64;

  // Index must be able to step one past the last channel.
  function automatic int idx_width(input int channels);
    return $clog2(channels + 1);
  endfunction

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/axis_sweep_data_mover_if.sv
// Request, response and output streams of the sweep data mover, bundled in one interface.
interface axis_sweep_data_mover_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEST_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] req_data;
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DEST_WIDTH-1:0] out_dest;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output req_data, req_valid, input req_ready,
    input rsp_data, rsp_valid, output rsp_ready,
    output out_data, out_dest, out_valid, out_last, input out_ready
  );

  modport slave (
    input req_data, req_valid, output req_ready,
    output rsp_data, rsp_valid, input rsp_ready,
    input out_data, out_dest, out_valid, out_last, output out_ready
  );
endinterface

// File: rtl/axis_sweep_data_mover.sv
// Sweeps the enabled channels once per start: request a word, wait (bounded) for the
// response, forward it tagged with the channel's destination.
module axis_sweep_data_mover
  import axis_data_mover_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEST_WIDTH     = 8,
  parameter int CHANNEL_NUMBER = 4,
  parameter logic [ADDR_WIDTH-1:0] SOURCE_ADDR [CHANNEL_NUMBER] = '{1, 2, 3, 4},
  parameter logic [31:0]           TARGET_ADDR [CHANNEL_NUMBER] = '{1, 2, 3, 4},
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CHANNEL_NUMBER-1:0] channel_enable,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_error,
  axis_sweep_data_mover_if.master   bus
);

  localparam int IDX_W = idx_width(CHANNEL_NUMBER);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNEL_NUMBER - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

  // Table lookups are loops so the index may be wider than the table.
  function automatic logic [ADDR_WIDTH-1:0] src_of(input logic [IDX_W-1:0] i);
    src_of = '0;
    for (int c = 0; c < CHANNEL_NUMBER; c++)
      if (i == IDX_W'(c)) src_of = SOURCE_ADDR[c];
  endfunction

  function automatic logic [DEST_WIDTH-1:0] dest_of(input logic [IDX_W-1:0] i);
    dest_of = '0;
    for (int c = 0; c < CHANNEL_NUMBER; c++)
      if (i == IDX_W'(c)) dest_of = DEST_WIDTH'(TARGET_ADDR[c]);
  endfunction

  function automatic logic en_of(input logic [CHANNEL_NUMBER-1:0] m, input logic [IDX_W-1:0] i);
    en_of = 1'b0;
    for (int c = 0; c < CHANNEL_NUMBER; c++)
      if (i == IDX_W'(c)) en_of = m[c];
  endfunction

  function automatic logic [IDX_W-1:0] highest(input logic [CHANNEL_NUMBER-1:0] m);
    highest = '0;
    for (int c = 0; c < CHANNEL_NUMBER; c++)
      if (m[c]) highest = IDX_W'(c);
  endfunction

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CHANNEL_NUMBER-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      terr_q, terr_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    terr_d  = terr_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        mask_d  = channel_enable;
        terr_d  = 1'b0;
        idx_d   = '0;
        state_d = S_SEEK;
      end
      S_SEEK: begin
        // A timeout on the last channel leaves idx one past the end.
        if (idx_q > LAST_IDX) state_d = S_FINISH;
        else if (en_of(mask_q, idx_q)) state_d = S_REQUEST;
        else begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = S_FINISH;
        end
      end
      S_REQUEST: if (bus.req_ready) begin
        cnt_d   = '0;
        state_d = S_RESPONSE;
      end
      S_RESPONSE: begin
        if (bus.rsp_valid) begin
          data_d  = bus.rsp_data;
          state_d = S_EMIT;
        end else if (cnt_q == CNT_MAX) begin
          terr_d  = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = S_SEEK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EMIT: if (bus.out_ready) begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == LAST_IDX) ? S_FINISH : S_SEEK;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      terr_q  <= terr_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FINISH);
  assign timeout_error = terr_q;

  assign bus.req_valid = (state_q == S_REQUEST);
  assign bus.req_data  = src_of(idx_q);
  assign bus.rsp_ready = (state_q == S_RESPONSE);
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.out_data  = data_q;
  assign bus.out_dest  = bus.out_valid ? dest_of(idx_q) : '0;
  assign bus.out_last  = bus.out_valid && (idx_q == highest(mask_q));

endmodule

// File: doc/axis_sweep_data_mover.md
AXIS_SWEEP_DATA_MOVER -- requirements
Module: axis_sweep_data_mover

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, request address width.
- DEST_WIDTH, 8, data_out dest width.
- CHANNEL_NUMBER, 4, number of channels, range 1..64.
- SOURCE_ADDR, '{1,2,3,4}, per-channel read address.
- TARGET_ADDR, '{1,2,3,4}, per-channel output dest.
- TIMEOUT_CYCLES, 64, maximum wait for a response, range 1..65535.

REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle sweep trigger.
- channel_enable, in, CHANNEL_NUMBER, per-channel enable mask.
- busy, out, 1, sweep in progress.
- done, out, 1, one-cycle end-of-sweep pulse.
- timeout_error, out, 1, sticky, at least one channel timed out in the last sweep.
- data_request, axi_stream master, ADDR_WIDTH, data = source address; valid/ready.
- data_response, axi_stream slave, DATA_WIDTH, data/valid/ready.
- data_out, axi_stream master, DATA_WIDTH + DEST_WIDTH, data/dest/valid/ready/tlast.

Function
REQ-003 FSM states: IDLE, SEEK, REQUEST, RESPONSE, EMIT, FINISH.
REQ-004 IDLE:
- start=1 registers channel_enable into an internal mask, clears timeout_error, sets channel index 0 and moves to SEEK.
- start while not IDLE is ignored.
REQ-005 SEEK, index enabled -> REQUEST.
REQ-006 SEEK, index disabled -> increment index; if index passes CHANNEL_NUMBER-1 -> FINISH.
REQ-007 SEEK takes one cycle per channel, so an all-zero mask gives done exactly CHANNEL_NUMBER+1 cycles after start.
REQ-008 REQUEST:
- data_request.valid=1, data = SOURCE_ADDR[index].
- Valid held until ready=1; transfer happens on the valid&&ready cycle, then -> RESPONSE.
REQ-009 RESPONSE:
- data_response.ready=1 only in this state.
- On valid&&ready, capture data into an output register -> EMIT.
- ready=0 in every other state.
REQ-010 RESPONSE timeout:
- Cycle counter cleared on entry.
- If TIMEOUT_CYCLES cycles pass with no response handshake: set timeout_error, skip the channel with no output, increment index -> SEEK.
REQ-011 EMIT:
- data_out.valid=1, data = captured word, dest = TARGET_ADDR[index].
- tlast=1 iff index is the highest enabled bit in the registered mask.
- Outputs stable until ready=1; then increment index -> SEEK, or -> FINISH if index was CHANNEL_NUMBER-1.
REQ-012 If the highest enabled channel times out, no tlast is produced in that sweep.
REQ-013 FINISH: done=1 for exactly one cycle -> IDLE.
REQ-014 busy=1 in every state except IDLE.
REQ-015 Latency:
- start at cycle 0, channel 0 enabled, request ready=1 -> data_request.valid at cycle 2.
- Response handshake at cycle N -> data_out.valid at cycle N+1.
REQ-016 A late response arriving after a timeout, while outside RESPONSE, is not accepted (ready=0).
REQ-017 Changes on channel_enable during a sweep have no effect on that sweep.
REQ-018 DEST_WIDTH narrower than a TARGET_ADDR value truncates the value to its low bits.
REQ-019 Index width is $clog2(CHANNEL_NUMBER+1) bits.
REQ-020 Timeout counter width is $clog2(TIMEOUT_CYCLES+1) bits.

Reset
REQ-021 reset=1 at a clock edge forces IDLE from any state, including mid-handshake.
REQ-022 Reset values:
- busy=0, done=0, timeout_error=0.
- data_request.valid=0, data_response.ready=0.
- data_out.valid=0, data_out.tlast=0, data=0, dest=0.
- index=0, registered mask=0.
REQ-023 start asserted in the same cycle as reset is ignored.

Structure
REQ-024 The FSM state enum and a localparam for index and counter width helpers live in a shared package axis_data_mover_pkg.
REQ-025 No sub-modules: single flat module.
REQ-026 Priority encoder for the highest enabled channel (tlast) is an internal function.

Verification
REQ-027 Bench scenarios:
- CHANNEL_NUMBER=3, mask 3'b111, responder returns 'hA,'hB,'hC after 2 cycles -> data_out (data,dest) = ('hA,1),('hB,2),('hC,3), tlast on the third only, done once, timeout_error=0.
- Mask 3'b101 -> only dest 1 and 3 emitted, no request issued for SOURCE_ADDR[1], tlast on dest 3.
- Responder silent for channel 2, TIMEOUT_CYCLES=8 -> channel 2 skipped after 8 cycles, timeout_error=1, channels 1 and 3 emitted; a response injected 2 cycles later is not accepted.
- data_out.ready held low for 10 cycles during EMIT -> data/dest/tlast stable across all 10 cycles, exactly one transfer.
- Mask all zero -> no requests, done pulses at start+CHANNEL_NUMBER+1 cycles, busy high for CHANNEL_NUMBER+1 cycles.
- reset asserted while waiting in RESPONSE -> next cycle busy=0 and all valids 0; a new start then completes a full sweep.
